// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: FSM encoding and screen/colour-key defaults.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [8:0] TRANSPARENT_DEF = 9'h12E;
  localparam int         SCREEN_W_DEF    = 160;
  localparam int         SCREEN_H_DEF    = 120;

endpackage

// File: rtl/sprite_addr_gen.sv
// Row/column walker for one sprite: produces the address and coordinates of the
// next pixel to issue (combinationally) and flags when the current pixel is the last.
module sprite_addr_gen #(
  parameter int DIM_W  = 6,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic              flip_x_i,
  input  logic              flip_y_i,
  input  logic [ADDR_W-1:0] frame_base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DIM_W-1:0]  ncol_o,
  output logic [DIM_W-1:0]  nrow_o,
  output logic              last_o
);

  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] w_a, h_a;

  assign w_a = ADDR_W'(width_i);
  assign h_a = ADDR_W'(height_i);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    rb_d  = rb_q;
    if (load_i) begin
      col_d = '0;
      row_d = '0;
      rb_d  = frame_base_i + (flip_y_i ? (h_a - ADDR_W'(1)) * w_a : '0);
    end else if (step_i) begin
      if (col_q == width_i - DIM_W'(1)) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
        // A vertically mirrored sprite walks its rows backwards through memory.
        rb_d  = flip_y_i ? rb_q - w_a : rb_q + w_a;
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  assign addr_o = rb_d + (flip_x_i ? w_a - ADDR_W'(1) - ADDR_W'(col_d) : ADDR_W'(col_d));
  assign ncol_o = col_d;
  assign nrow_o = row_d;
  assign last_o = (col_q == width_i - DIM_W'(1)) && (row_q == height_i - DIM_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
      rb_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      rb_q  <= rb_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite-to-framebuffer engine: streams one sprite-memory address per cycle and
// emits a plot strobe for every visible, opaque, on-screen pixel as its data returns.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 9,
  parameter int DIM_W    = 6,
  parameter int ANIM_W   = 3,
  parameter int ADDR_W   = 14,
  parameter int MEM_LAT  = 1,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(TRANSPARENT_DEF)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [X_W-1:0]     Xin,
  input  logic [Y_W-1:0]     Yin,
  input  logic [DIM_W-1:0]   Width,
  input  logic [DIM_W-1:0]   Height,
  input  logic [ANIM_W-1:0]  AnimStep,
  input  logic               FlipX,
  input  logic               FlipY,
  input  logic [2:0]         Sprite,
  input  logic [COLOR_W-1:0] DataIn,
  output logic [2:0]         MemSel,
  output logic [ADDR_W-1:0]  Address,
  output logic [X_W-1:0]     Xout,
  output logic [Y_W-1:0]     Yout,
  output logic [COLOR_W-1:0] Color,
  output logic               Plot,
  output logic               Busy,
  output logic               Done,
  output logic [1:0]         dbg_state_o
);

  localparam int DRN_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e             state_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [DIM_W-1:0]   w_q, h_q;
  logic [ANIM_W-1:0]  anim_q;
  logic               fx_q, fy_q;
  logic [2:0]         memsel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               busy_q, done_q;
  logic [DRN_W-1:0]   drain_q;

  // Stage 0 is aligned with Address; stage MEM_LAT is aligned with DataIn.
  logic               vld_q [0:MEM_LAT];
  logic [X_W:0]       xs_q  [0:MEM_LAT];
  logic [Y_W:0]       ys_q  [0:MEM_LAT];

  logic               gen_load, gen_step, gen_last;
  logic [ADDR_W-1:0]  gen_addr, frame_base;
  logic [DIM_W-1:0]   gen_col, gen_row;

  assign frame_base = ADDR_W'(anim_q) * ADDR_W'(w_q) * ADDR_W'(h_q);
  assign gen_load   = (state_q == ST_LOAD) && (w_q != '0) && (h_q != '0);
  assign gen_step   = (state_q == ST_SCAN) && !gen_last;

  sprite_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .load_i       (gen_load),
    .step_i       (gen_step),
    .width_i      (w_q),
    .height_i     (h_q),
    .flip_x_i     (fx_q),
    .flip_y_i     (fy_q),
    .frame_base_i (frame_base),
    .addr_o       (gen_addr),
    .ncol_o       (gen_col),
    .nrow_o       (gen_row),
    .last_o       (gen_last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      anim_q   <= '0;
      fx_q     <= 1'b0;
      fy_q     <= 1'b0;
      memsel_q <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drain_q  <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        vld_q[i] <= 1'b0;
        xs_q[i]  <= '0;
        ys_q[i]  <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      vld_q[0] <= gen_load | gen_step;
      xs_q[0]  <= {1'b0, x_q} + (X_W+1)'(gen_col);
      ys_q[0]  <= {1'b0, y_q} + (Y_W+1)'(gen_row);
      for (int i = 1; i <= MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        xs_q[i]  <= xs_q[i-1];
        ys_q[i]  <= ys_q[i-1];
      end
      if (gen_load | gen_step) addr_q <= gen_addr;

      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            x_q      <= Xin;
            y_q      <= Yin;
            w_q      <= Width;
            h_q      <= Height;
            anim_q   <= AnimStep;
            fx_q     <= FlipX;
            fy_q     <= FlipY;
            memsel_q <= Sprite;
            busy_q   <= 1'b1;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if ((w_q == '0) || (h_q == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (gen_last) begin
            drain_q <= '0;
            done_q  <= (MEM_LAT == 1);
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Done is raised on entry to the final drain cycle, alongside the last plot.
          if (drain_q == DRN_W'(MEM_LAT - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            drain_q <= drain_q + DRN_W'(1);
            done_q  <= (int'(drain_q) + 2 == MEM_LAT);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MemSel      = memsel_q;
  assign Address     = addr_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign dbg_state_o = state_q;
  assign Xout        = xs_q[MEM_LAT][X_W-1:0];
  assign Yout        = ys_q[MEM_LAT][Y_W-1:0];
  assign Color       = DataIn;
  assign Plot        = vld_q[MEM_LAT] && (DataIn != TRANSPARENT) &&
                       (xs_q[MEM_LAT] < (X_W+1)'(SCREEN_W)) &&
                       (ys_q[MEM_LAT] < (Y_W+1)'(SCREEN_H));

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (memory latency 1 and 3) share stimulus
// and are scored against a per-pixel reference model of the draw.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam logic [8:0] TRANSP = 9'h12E;

  logic       clk = 1'b0;
  logic       rst, start, fx, fy;
  logic [7:0] xin;
  logic [6:0] yin;
  logic [5:0] w_in, h_in;
  logic [2:0] anim, spr;

  logic [8:0]  din1, din3, color1, color3;
  logic [2:0]  memsel1, memsel3;
  logic [13:0] addr1, addr3;
  logic [7:0]  xout1, xout3;
  logic [6:0]  yout1, yout3;
  logic        plot1, plot3, busy1, busy3, done1, done3;
  logic [1:0]  st1, st3;

  logic [8:0]  mem [0:16383];
  logic [13:0] ah1 [0:0];
  logic [13:0] ah3 [0:2];

  logic [39:0] exp1_q[$];
  logic [39:0] exp3_q[$];
  logic [13:0] exp_addr_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_blitter #(.MEM_LAT(1)) dut1 (
    .Clock(clk), .Reset(rst), .Start(start), .Xin(xin), .Yin(yin), .Width(w_in),
    .Height(h_in), .AnimStep(anim), .FlipX(fx), .FlipY(fy), .Sprite(spr), .DataIn(din1),
    .MemSel(memsel1), .Address(addr1), .Xout(xout1), .Yout(yout1), .Color(color1),
    .Plot(plot1), .Busy(busy1), .Done(done1), .dbg_state_o(st1)
  );

  sprite_blitter #(.MEM_LAT(3)) dut3 (
    .Clock(clk), .Reset(rst), .Start(start), .Xin(xin), .Yin(yin), .Width(w_in),
    .Height(h_in), .AnimStep(anim), .FlipX(fx), .FlipY(fy), .Sprite(spr), .DataIn(din3),
    .MemSel(memsel3), .Address(addr3), .Xout(xout3), .Yout(yout3), .Color(color3),
    .Plot(plot3), .Busy(busy3), .Done(done3), .dbg_state_o(st3)
  );

  // Sprite memory model: data appears MEM_LAT cycles after the address.
  always @(posedge clk) begin
    ah1[0] <= addr1;
    ah3[0] <= addr3;
    ah3[1] <= ah3[0];
    ah3[2] <= ah3[1];
  end
  assign din1 = mem[ah1[0]];
  assign din3 = mem[ah3[2]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16384; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? TRANSP : 9'($urandom);
  endtask

  task automatic run_draw(input logic [7:0] x, input logic [6:0] y, input int w, input int h,
                          input int a, input bit fxv, input bit fyv, input logic [2:0] s,
                          input bit mid_start, output int nplot,
                          output logic [13:0] first_a, output logic [13:0] last_a);
    int n, addr, xs, ys, k;
    int dn1, dn3, bc1, bc3, ed1, ed3, eb1, eb3;
    logic [13:0] addr_before;
    logic [8:0]  col;
    exp1_q.delete();
    exp3_q.delete();
    exp_addr_q.delete();
    n = w * h;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        addr = (a * w * h + (fyv ? h - 1 - r : r) * w + (fxv ? w - 1 - c : c)) % 16384;
        k    = r * w + c;
        exp_addr_q.push_back(14'(addr));
        col = mem[addr];
        xs  = int'(x) + c;
        ys  = int'(y) + r;
        if (col != TRANSP && xs < 160 && ys < 120) begin
          exp1_q.push_back({16'(3 + k), 8'(xs), 7'(ys), col});
          exp3_q.push_back({16'(5 + k), 8'(xs), 7'(ys), col});
        end
      end
    end
    ed1 = (n == 0) ? 2 : n + 2;
    ed3 = (n == 0) ? 2 : n + 4;
    eb1 = (n == 0) ? 1 : n + 2;
    eb3 = (n == 0) ? 1 : n + 4;
    dn1 = 0; dn3 = 0; bc1 = 0; bc3 = 0; nplot = 0;
    first_a = '0; last_a = '0;
    addr_before = addr1;

    @(negedge clk);
    xin = x; yin = y; w_in = 6'(w); h_in = 6'(h); anim = 3'(a);
    fx = fxv; fy = fyv; spr = s; start = 1'b1;
    for (int cyc = 1; cyc <= n + 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check_eq("state_load", 64'(st1), 64'(ST_LOAD));
      if (n == 0) begin
        check_eq("addr_hold", addr1, addr_before);
      end else if (cyc >= 2 && cyc <= n + 1) begin
        check_eq("addr1", addr1, exp_addr_q[cyc-2]);
        check_eq("addr3", addr3, exp_addr_q[cyc-2]);
        if (cyc == 2) begin
          first_a = addr1;
          check_eq("memsel1", memsel1, s);
          check_eq("memsel3", memsel3, s);
        end
        if (cyc == n + 1) last_a = addr1;
      end
      if (plot1) begin
        nplot++;
        if (exp1_q.size() == 0) check_eq("plot1_extra", 1, 0);
        else check_eq("plot1", {16'(cyc), xout1, yout1, color1}, exp1_q.pop_front());
      end
      if (plot3) begin
        if (exp3_q.size() == 0) check_eq("plot3_extra", 1, 0);
        else check_eq("plot3", {16'(cyc), xout3, yout3, color3}, exp3_q.pop_front());
      end
      if (done1) begin dn1++; check_eq("done1_cyc", cyc, ed1); end
      if (done3) begin dn3++; check_eq("done3_cyc", cyc, ed3); end
      if (busy1) bc1++;
      if (busy3) bc3++;
      // Inputs are scrambled after the Start cycle; the latched descriptor must win.
      start = 1'b0;
      xin = 8'($urandom); yin = 7'($urandom); w_in = 6'($urandom); h_in = 6'($urandom);
      anim = 3'($urandom); fx = 1'($urandom); fy = 1'($urandom); spr = 3'($urandom);
      if (mid_start && cyc == 2 && n >= 4) start = 1'b1;
    end
    start = 1'b0;
    check_eq("plot1_missing", exp1_q.size(), 0);
    check_eq("plot3_missing", exp3_q.size(), 0);
    check_eq("done1_cnt", dn1, 1);
    check_eq("done3_cnt", dn3, 1);
    check_eq("busy1_cycles", bc1, eb1);
    check_eq("busy3_cycles", bc3, eb3);
  endtask

  task automatic run_reset_mid_scan();
    @(negedge clk);
    xin = 8'd5; yin = 7'd5; w_in = 6'd4; h_in = 6'd4; anim = 3'd0;
    fx = 1'b0; fy = 1'b0; spr = 3'd1; start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 6) begin
        check_eq("rst_plot1", plot1, 0);
        check_eq("rst_plot3", plot3, 0);
        check_eq("rst_busy1", busy1, 0);
        check_eq("rst_busy3", busy3, 0);
        check_eq("rst_addr3", addr3, 0);
        check_eq("rst_state3", 64'(st3), 64'(ST_IDLE));
        rst = 1'b0;
      end
      if (cyc == 7) begin
        check_eq("post_rst_plot3", plot3, 0);
        check_eq("post_rst_busy3", busy3, 0);
      end
      if (cyc == 5) rst = 1'b1;
    end
  endtask

  initial begin
    int np;
    logic [13:0] fa, la;
    rst = 1'b1; start = 1'b0; xin = '0; yin = '0; w_in = '0; h_in = '0;
    anim = '0; fx = 1'b0; fy = 1'b0; spr = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 9'h1FF;
    repeat (3) @(negedge clk);
    check_eq("reset_addr", addr1, 0);
    check_eq("reset_busy", busy1, 0);
    check_eq("reset_done", done1, 0);
    check_eq("reset_plot", plot1, 0);
    check_eq("reset_memsel", memsel1, 0);
    check_eq("reset_state", 64'(st1), 64'(ST_IDLE));
    rst = 1'b0;

    // Basic draw, opaque memory.
    run_draw(8'd10, 7'd20, 4, 2, 0, 1'b0, 1'b0, 3'd2, 1'b0, np, fa, la);
    check_eq("basic_plots", np, 8);
    check_eq("basic_first_addr", fa, 0);
    check_eq("basic_last_addr", la, 7);

    // Animation frame with both flips.
    fill_random();
    run_draw(8'd30, 7'd40, 4, 4, 2, 1'b1, 1'b1, 3'd5, 1'b0, np, fa, la);
    check_eq("flip_first_addr", fa, 47);
    check_eq("flip_last_addr", la, 32);

    // Checkerboard transparency.
    for (int i = 0; i < 16; i++) mem[i] = (((i / 4) + (i % 4)) % 2 == 1) ? 9'h007 : TRANSP;
    run_draw(8'd50, 7'd60, 4, 4, 0, 1'b0, 1'b0, 3'd0, 1'b0, np, fa, la);
    check_eq("trans_plots", np, 8);

    // Clipping at the bottom-right corner.
    for (int i = 0; i < 16; i++) mem[i] = 9'h1FF;
    run_draw(8'd158, 7'd118, 4, 4, 0, 1'b0, 1'b0, 3'd0, 1'b0, np, fa, la);
    check_eq("clip_plots", np, 4);

    // Zero-sized sprites and an ignored Start during SCAN.
    run_draw(8'd1, 7'd1, 0, 3, 1, 1'b0, 1'b0, 3'd3, 1'b0, np, fa, la);
    run_draw(8'd1, 7'd1, 3, 0, 1, 1'b0, 1'b0, 3'd3, 1'b0, np, fa, la);
    run_draw(8'd20, 7'd30, 5, 3, 1, 1'b0, 1'b1, 3'd4, 1'b1, np, fa, la);

    run_reset_mid_scan();
    run_draw(8'd70, 7'd80, 3, 3, 1, 1'b1, 1'b0, 3'd6, 1'b0, np, fa, la);

    fill_random();
    for (int t = 0; t < 24; t++) begin
      run_draw(8'($urandom), 7'($urandom),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
               $urandom_range(1, 12), $urandom_range(0, 7),
               1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), np, fa, la);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
